// File: rtl/img_win_pkg.sv
// Shared command codes and controller state encoding for the image window block.
package img_win_pkg;

    localparam int unsigned CMD_W = 4;

    localparam logic [CMD_W-1:0] CMD_WRITE = 4'h0;
    localparam logic [CMD_W-1:0] CMD_UP    = 4'h1;
    localparam logic [CMD_W-1:0] CMD_DOWN  = 4'h2;
    localparam logic [CMD_W-1:0] CMD_LEFT  = 4'h3;
    localparam logic [CMD_W-1:0] CMD_RIGHT = 4'h4;
    localparam logic [CMD_W-1:0] CMD_MAX   = 4'h5;
    localparam logic [CMD_W-1:0] CMD_MIN   = 4'h6;
    localparam logic [CMD_W-1:0] CMD_AVG   = 4'h7;
    localparam logic [CMD_W-1:0] CMD_ROTL  = 4'h8;
    localparam logic [CMD_W-1:0] CMD_ROTR  = 4'h9;
    localparam logic [CMD_W-1:0] CMD_MIRX  = 4'hA;
    localparam logic [CMD_W-1:0] CMD_MIRY  = 4'hB;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

endpackage

// File: rtl/img_win_alu.sv
// Combinational 2x2 window operator: a b on the upper row, c d on the lower.
module img_win_alu
    import img_win_pkg::*;
#(
    parameter int unsigned PIX_W = 8
) (
    input  logic [CMD_W-1:0] cmd,
    input  logic [PIX_W-1:0] a,
    input  logic [PIX_W-1:0] b,
    input  logic [PIX_W-1:0] c,
    input  logic [PIX_W-1:0] d,
    output logic [PIX_W-1:0] a_n,
    output logic [PIX_W-1:0] b_n,
    output logic [PIX_W-1:0] c_n,
    output logic [PIX_W-1:0] d_n
);

    localparam int unsigned SW = PIX_W + 2;

    logic [PIX_W-1:0] mx_ab, mx_cd, mx_all;
    logic [PIX_W-1:0] mn_ab, mn_cd, mn_all;
    logic [SW-1:0]    sum;

    always_comb begin
        mx_ab  = (a > b) ? a : b;
        mx_cd  = (c > d) ? c : d;
        mx_all = (mx_ab > mx_cd) ? mx_ab : mx_cd;
        mn_ab  = (a < b) ? a : b;
        mn_cd  = (c < d) ? c : d;
        mn_all = (mn_ab < mn_cd) ? mn_ab : mn_cd;
        sum    = SW'(a) + SW'(b) + SW'(c) + SW'(d);

        a_n = a;
        b_n = b;
        c_n = c;
        d_n = d;
        case (cmd)
            CMD_MAX:  {a_n, b_n, c_n, d_n} = {4{mx_all}};
            CMD_MIN:  {a_n, b_n, c_n, d_n} = {4{mn_all}};
            CMD_AVG:  {a_n, b_n, c_n, d_n} = {4{sum[SW-1:2]}};
            CMD_ROTL: begin a_n = b; b_n = d; d_n = c; c_n = a; end
            CMD_ROTR: begin a_n = c; c_n = d; d_n = b; b_n = a; end
            CMD_MIRX: begin a_n = c; c_n = a; b_n = d; d_n = b; end
            CMD_MIRY: begin a_n = b; b_n = a; c_n = d; d_n = c; end
            default:  ;
        endcase
    end

endmodule

// File: rtl/img_win_ctrl.sv
// Image window controller: loads the image from ROM, applies 2x2 window
// commands to the internal buffer, and streams the buffer to RAM on request.
module img_win_ctrl
    import img_win_pkg::*;
#(
    parameter  int unsigned IMG_W = 8,
    parameter  int unsigned IMG_H = 8,
    parameter  int unsigned PIX_W = 8,
    localparam int unsigned AW    = $clog2(IMG_W * IMG_H)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [CMD_W-1:0] cmd,
    input  logic             cmd_valid,
    input  logic [PIX_W-1:0] IROM_Q,
    output logic             IROM_rd,
    output logic [AW-1:0]    IROM_A,
    output logic             IRAM_valid,
    output logic [PIX_W-1:0] IRAM_D,
    output logic [AW-1:0]    IRAM_A,
    output logic             busy,
    output logic             done
);

    localparam int unsigned N  = IMG_W * IMG_H;
    localparam int unsigned XW = $clog2(IMG_W);
    localparam int unsigned YW = $clog2(IMG_H);

    localparam logic [AW-1:0] LAST   = AW'(N - 1);
    localparam logic [XW-1:0] X_INIT = XW'(IMG_W / 2);
    localparam logic [YW-1:0] Y_INIT = YW'(IMG_H / 2);
    localparam logic [XW-1:0] X_MAX  = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_MAX  = YW'(IMG_H - 1);
    localparam logic [XW-1:0] X_MIN  = XW'(1);
    localparam logic [YW-1:0] Y_MIN  = YW'(1);

    state_t state, state_nxt;

    logic             rd_nxt, ram_v_nxt, busy_nxt, done_nxt;
    logic [AW-1:0]    rom_a_nxt, ram_a_nxt;
    logic [PIX_W-1:0] ram_d_nxt;
    logic             cap_valid, cap_v_nxt;
    logic [AW-1:0]    cap_addr, cap_a_nxt;
    logic [CMD_W-1:0] cmd_r, cmd_nxt;
    logic [XW-1:0]    px, px_nxt, pxm1;
    logic [YW-1:0]    py, py_nxt, pym1;
    logic             load_we_c, win_we_c;

    logic [PIX_W-1:0] mem [N];

    logic [AW-1:0]    addr_a, addr_b, addr_c, addr_d;
    logic [PIX_W-1:0] win_a, win_b, win_c, win_d;
    logic [PIX_W-1:0] new_a, new_b, new_c, new_d;

    // Window addresses: row-major with power-of-2 width, so {y, x} is the address.
    assign pxm1   = px - XW'(1);
    assign pym1   = py - YW'(1);
    assign addr_a = {pym1, pxm1};
    assign addr_b = {pym1, px};
    assign addr_c = {py, pxm1};
    assign addr_d = {py, px};
    assign win_a  = mem[addr_a];
    assign win_b  = mem[addr_b];
    assign win_c  = mem[addr_c];
    assign win_d  = mem[addr_d];

    img_win_alu #(.PIX_W(PIX_W)) u_alu (
        .cmd (cmd_r),
        .a   (win_a),
        .b   (win_b),
        .c   (win_c),
        .d   (win_d),
        .a_n (new_a),
        .b_n (new_b),
        .c_n (new_c),
        .d_n (new_d)
    );

    always_comb begin
        state_nxt = state;
        rd_nxt    = 1'b0;
        rom_a_nxt = IROM_A;
        ram_v_nxt = 1'b0;
        ram_a_nxt = IRAM_A;
        ram_d_nxt = IRAM_D;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        cap_v_nxt = 1'b0;
        cap_a_nxt = cap_addr;
        cmd_nxt   = cmd_r;
        px_nxt    = px;
        py_nxt    = py;
        load_we_c = 1'b0;
        win_we_c  = 1'b0;

        case (state)
            // ROM data lags its address by one cycle; cap_* tracks the address in flight.
            ST_LOAD: begin
                rd_nxt    = 1'b1;
                busy_nxt  = 1'b1;
                cap_v_nxt = 1'b1;
                cap_a_nxt = IROM_A;
                if (IROM_A != LAST) begin
                    rom_a_nxt = IROM_A + AW'(1);
                end
                if (cap_valid) begin
                    load_we_c = 1'b1;
                    if (cap_addr == LAST) begin
                        state_nxt = ST_IDLE;
                        rd_nxt    = 1'b0;
                        busy_nxt  = 1'b0;
                        cap_v_nxt = 1'b0;
                    end
                end
            end
            ST_IDLE: begin
                busy_nxt = 1'b0;
                if (cmd_valid) begin
                    cmd_nxt  = cmd;
                    busy_nxt = 1'b1;
                    if (cmd == CMD_WRITE) begin
                        state_nxt = ST_WRITE;
                        ram_v_nxt = 1'b1;
                        ram_a_nxt = '0;
                        ram_d_nxt = mem[ram_a_nxt];
                    end else begin
                        state_nxt = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
                case (cmd_r)
                    CMD_UP:    if (py > Y_MIN) py_nxt = pym1;
                    CMD_DOWN:  if (py < Y_MAX) py_nxt = py + YW'(1);
                    CMD_LEFT:  if (px > X_MIN) px_nxt = pxm1;
                    CMD_RIGHT: if (px < X_MAX) px_nxt = px + XW'(1);
                    default:   win_we_c = (cmd_r >= CMD_MAX) && (cmd_r <= CMD_MIRY);
                endcase
            end
            ST_WRITE: begin
                if (IRAM_A == LAST) begin
                    state_nxt = ST_IDLE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end else begin
                    ram_v_nxt = 1'b1;
                    ram_a_nxt = IRAM_A + AW'(1);
                    ram_d_nxt = mem[ram_a_nxt];
                end
            end
            default: state_nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_LOAD;
            IROM_rd    <= 1'b1;
            IROM_A     <= '0;
            IRAM_valid <= 1'b0;
            IRAM_A     <= '0;
            IRAM_D     <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            cap_valid  <= 1'b0;
            cap_addr   <= '0;
            cmd_r      <= CMD_WRITE;
            px         <= X_INIT;
            py         <= Y_INIT;
        end else begin
            state      <= state_nxt;
            IROM_rd    <= rd_nxt;
            IROM_A     <= rom_a_nxt;
            IRAM_valid <= ram_v_nxt;
            IRAM_A     <= ram_a_nxt;
            IRAM_D     <= ram_d_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            cap_valid  <= cap_v_nxt;
            cap_addr   <= cap_a_nxt;
            cmd_r      <= cmd_nxt;
            px         <= px_nxt;
            py         <= py_nxt;
        end
    end

    // Pixel buffer keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (load_we_c) begin
            mem[cap_addr] <= IROM_Q;
        end
        if (win_we_c) begin
            mem[addr_a] <= new_a;
            mem[addr_b] <= new_b;
            mem[addr_c] <= new_c;
            mem[addr_d] <= new_d;
        end
    end

endmodule

// File: tb/tb_img_win_ctrl.sv
// Bench for img_win_ctrl: an 8x8 and a 16x4 instance checked cycle by cycle
// against a pixel-array model driven alongside the directed command sequence.
module tb_img_win_ctrl;

    localparam int unsigned AW = 6;
    localparam int unsigned PW = 8;
    localparam int          NP = 64;

    logic          clk;
    logic          reset_n0, reset_n1;
    logic [3:0]    cmd;
    logic          cmd_valid;
    logic [PW-1:0] rom_q0, rom_q1;
    logic          rd0, rd1, ram_v0, ram_v1, busy0, busy1, done0, done1;
    logic [AW-1:0] rom_a0, rom_a1, ram_a0, ram_a1;
    logic [PW-1:0] ram_d0, ram_d1;

    logic [PW-1:0] rom [NP];
    logic          sel;

    img_win_ctrl #(.IMG_W(8), .IMG_H(8), .PIX_W(PW)) dut0 (
        .clk(clk), .reset_n(reset_n0), .cmd(cmd), .cmd_valid(cmd_valid),
        .IROM_Q(rom_q0), .IROM_rd(rd0), .IROM_A(rom_a0),
        .IRAM_valid(ram_v0), .IRAM_D(ram_d0), .IRAM_A(ram_a0),
        .busy(busy0), .done(done0)
    );

    img_win_ctrl #(.IMG_W(16), .IMG_H(4), .PIX_W(PW)) dut1 (
        .clk(clk), .reset_n(reset_n1), .cmd(cmd), .cmd_valid(cmd_valid),
        .IROM_Q(rom_q1), .IROM_rd(rd1), .IROM_A(rom_a1),
        .IRAM_valid(ram_v1), .IRAM_D(ram_d1), .IRAM_A(ram_a1),
        .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROMs, one cycle of read latency.
    always @(posedge clk) begin
        if (rd0) rom_q0 <= rom[rom_a0];
        if (rd1) rom_q1 <= rom[rom_a1];
    end

    logic          obs_busy, obs_done, obs_rd, obs_ram_v;
    logic [AW-1:0] obs_rom_a, obs_ram_a;
    logic [PW-1:0] obs_ram_d;
    assign obs_busy  = sel ? busy1  : busy0;
    assign obs_done  = sel ? done1  : done0;
    assign obs_rd    = sel ? rd1    : rd0;
    assign obs_ram_v = sel ? ram_v1 : ram_v0;
    assign obs_rom_a = sel ? rom_a1 : rom_a0;
    assign obs_ram_a = sel ? ram_a1 : ram_a0;
    assign obs_ram_d = sel ? ram_d1 : ram_d0;

    // Expected outputs for the current cycle.
    bit e_busy, e_done, e_rd, e_ram_v, e_rom_care, e_ram_care;
    int e_rom_a, e_ram_a, e_ram_d;
    bit chk_on, pin_req;
    int pin_idx, pin_val;

    int n_checks, n_errors;
    int seen [NP];

    // Image model.
    int img_m [NP];
    int img_w, img_h, px_m, py_m;

    function automatic void chk(input string nm, input int act, input int exp_v);
        n_checks = n_checks + 1;
        if (act != exp_v) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy", int'(obs_busy), int'(e_busy));
            chk("done", int'(obs_done), int'(e_done));
            chk("irom_rd", int'(obs_rd), int'(e_rd));
            chk("iram_valid", int'(obs_ram_v), int'(e_ram_v));
            if (e_rom_care) chk("irom_a", int'(obs_rom_a), e_rom_a);
            if (e_ram_care) begin
                chk("iram_a", int'(obs_ram_a), e_ram_a);
                chk("iram_d", int'(obs_ram_d), e_ram_d);
            end
            if (obs_ram_v) seen[obs_ram_a] = int'(obs_ram_d);
            if (pin_req) chk($sformatf("pix%0d", pin_idx), seen[pin_idx], pin_val);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_base(input bit b, input bit dn, input bit rd);
        e_busy = b; e_done = dn; e_rd = rd; e_ram_v = 1'b0;
        e_rom_care = 1'b0; e_ram_care = 1'b0;
        e_rom_a = 0; e_ram_a = 0; e_ram_d = 0;
    endtask

    task automatic exp_idle();
        exp_base(1'b0, 1'b0, 1'b0);
    endtask

    task automatic exp_reset();
        exp_base(1'b1, 1'b0, 1'b1);
        e_rom_care = 1'b1;
        e_ram_care = 1'b1;
    endtask

    task automatic set_rst(input logic v);
        if (sel) reset_n1 = v;
        else     reset_n0 = v;
    endtask

    // Release reset and expect N+1 busy cycles: N address cycles plus the final capture.
    task automatic do_load();
        set_rst(1'b1);
        for (int k = 0; k <= NP; k++) begin
            exp_base(1'b1, 1'b0, 1'b1);
            e_rom_care = (k < NP);
            e_rom_a    = k;
            cyc();
        end
        for (int k = 0; k < NP; k++) img_m[k] = int'(rom[k]);
        px_m = img_w / 2;
        py_m = img_h / 2;
        exp_idle();
        cyc();
    endtask

    task automatic do_reset();
        set_rst(1'b0);
        exp_reset();
        cyc();
        cyc();
        do_load();
    endtask

    task automatic apply_cmd(input int c);
        int p[4];
        int v[4];
        int m;
        p[0] = (py_m - 1) * img_w + px_m - 1;
        p[1] = p[0] + 1;
        p[2] = p[0] + img_w;
        p[3] = p[2] + 1;
        for (int i = 0; i < 4; i++) v[i] = img_m[p[i]];
        case (c)
            1: if (py_m > 1) py_m = py_m - 1;
            2: if (py_m < img_h - 1) py_m = py_m + 1;
            3: if (px_m > 1) px_m = px_m - 1;
            4: if (px_m < img_w - 1) px_m = px_m + 1;
            5, 6, 7: begin
                m = v[0];
                for (int i = 1; i < 4; i++) begin
                    if (c == 5 && v[i] > m) m = v[i];
                    if (c == 6 && v[i] < m) m = v[i];
                end
                if (c == 7) m = (v[0] + v[1] + v[2] + v[3]) / 4;
                for (int i = 0; i < 4; i++) img_m[p[i]] = m;
            end
            8:  begin img_m[p[0]] = v[1]; img_m[p[1]] = v[3]; img_m[p[3]] = v[2]; img_m[p[2]] = v[0]; end
            9:  begin img_m[p[0]] = v[2]; img_m[p[2]] = v[3]; img_m[p[3]] = v[1]; img_m[p[1]] = v[0]; end
            10: begin img_m[p[0]] = v[2]; img_m[p[2]] = v[0]; img_m[p[1]] = v[3]; img_m[p[3]] = v[1]; end
            11: begin img_m[p[0]] = v[1]; img_m[p[1]] = v[0]; img_m[p[2]] = v[3]; img_m[p[3]] = v[2]; end
            default: ;
        endcase
    endtask

    // Write-out; optionally hold cmd_valid over cycles hold_from..hold_to,
    // or pull reset at write cycle rst_at.
    task automatic write_cmd(input int hold_from, input int hold_to, input int rst_at);
        bit aborted;
        aborted = 1'b0;
        exp_idle();
        cmd = 4'h0;
        cmd_valid = 1'b1;
        cyc();
        cmd_valid = 1'b0;
        for (int k = 0; k < NP; k++) begin
            if (k == rst_at) begin
                exp_reset();
                #2;
                set_rst(1'b0);
                cyc();
                cyc();
                do_load();
                aborted = 1'b1;
                break;
            end
            exp_base(1'b1, 1'b0, 1'b0);
            e_ram_v    = 1'b1;
            e_ram_care = 1'b1;
            e_ram_a    = k;
            e_ram_d    = img_m[k];
            cmd        = 4'h5;
            cmd_valid  = (k >= hold_from) && (k <= hold_to);
            cyc();
        end
        cmd_valid = 1'b0;
        if (!aborted) begin
            exp_base(1'b0, 1'b1, 1'b0);
            cyc();
            exp_idle();
            cyc();
        end
    endtask

    task automatic issue(input int c);
        if (c == 0) begin
            write_cmd(-1, -1, -1);
        end else begin
            exp_idle();
            cmd = 4'(c);
            cmd_valid = 1'b1;
            cyc();
            cmd_valid = 1'b0;
            exp_base(1'b1, 1'b0, 1'b0);
            cyc();
            apply_cmd(c);
            exp_idle();
            cyc();
        end
    endtask

    task automatic pin(input int idx, input int val);
        exp_idle();
        pin_idx = idx;
        pin_val = val;
        pin_req = 1'b1;
        cyc();
        pin_req = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < NP; k++) rom[k] = 8'(k);
        reset_n0 = 1'b0; reset_n1 = 1'b0;
        cmd = 4'h0; cmd_valid = 1'b0; sel = 1'b0;
        chk_on = 1'b0; pin_req = 1'b0; pin_idx = 0; pin_val = 0;
        n_checks = 0; n_errors = 0;
        img_w = 8; img_h = 8; px_m = 4; py_m = 4;
        exp_reset();
        @(posedge clk);
        #1;
        chk_on = 1'b1;

        do_reset();
        exp_idle();
        cyc();

        issue(0);
        pin(0, 0); pin(9, 9); pin(63, 63);

        repeat (5) issue(3);
        issue(5);
        issue(0);
        pin(24, 33); pin(25, 33); pin(32, 33); pin(33, 33); pin(26, 26);

        do_reset();
        issue(7);
        issue(0);
        pin(27, 31); pin(28, 31); pin(35, 31); pin(36, 31);

        do_reset();
        issue(9);
        issue(0);
        pin(27, 35); pin(28, 27); pin(36, 28); pin(35, 36);

        issue(8); issue(10); issue(11); issue(6);
        repeat (5) issue(4);
        repeat (5) issue(1);
        issue(7);
        issue(0);

        issue(14);
        write_cmd(5, 20, -1);
        issue(0);

        write_cmd(-1, -1, 10);
        issue(0);
        pin(10, 10);

        reset_n0 = 1'b0;
        sel = 1'b1;
        img_w = 16;
        img_h = 4;
        do_reset();
        repeat (2) issue(2);
        issue(5);
        issue(0);
        pin(39, 56); pin(40, 56); pin(55, 56); pin(56, 56); pin(41, 41);

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
